// File: rtl/tlc_farm_sensor_cond.sv
// tlc_farm_sensor_cond: synchronise, debounce and count farm-road loop arrivals, latching a request until farm green
module tlc_farm_sensor_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loop_raw,
    input  logic [2:0]       light_farm,
    input  logic             clr_cnt,
    output logic             sensor,
    output logic [CNT_W-1:0] vehicle_cnt,
    output logic             overflow
);
    localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SERVE} state_t;

    state_t        state, state_nx;
    logic          s1, s2, loop_deb, arrival, green;
    logic [DW-1:0] deb_cnt;

    assign green   = light_farm == 3'b001;
    assign arrival = s2 & ~loop_deb & (deb_cnt == DEB_MAX);
    assign sensor  = (state == WAIT) | ((state == SERVE) & loop_deb);

    // two-flop synchroniser feeding a run-length debouncer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            loop_deb <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            s1 <= loop_raw;
            s2 <= s1;
            if (s2 == loop_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_MAX) begin
                loop_deb <= s2;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // saturating arrival counter; clear wins over history but still counts a same-cycle arrival
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vehicle_cnt <= '0;
            overflow    <= 1'b0;
        end else if (clr_cnt) begin
            vehicle_cnt <= CNT_W'(arrival);
            overflow    <= 1'b0;
        end else if (arrival) begin
            if (&vehicle_cnt) overflow <= 1'b1;
            else vehicle_cnt <= vehicle_cnt + CNT_W'(1);
        end
    end

    // request state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // request latched on arrival, served while farm green, re-armed if a car is still on the loop
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)  ? (arrival ? WAIT : IDLE) :
                   (state == WAIT)  ? (green ? SERVE : WAIT) :
                   (state == SERVE) ? (green ? SERVE : (loop_deb ? WAIT : IDLE)) :
                   IDLE;
    end
endmodule

// File: tb/tb_tlc_farm_sensor_cond.sv
// tb_tlc_farm_sensor_cond: directed and randomized checks of the loop conditioner against a behavioural model
module tb_tlc_farm_sensor_cond;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       loop_raw = 1'b0;
    logic [2:0] light_farm = 3'b100;
    logic       clr_cnt = 1'b0;
    logic       sensor, sensor3, overflow, ov3;
    logic [7:0] vehicle_cnt;
    logic [2:0] cnt3;

    int checks = 0;
    int failures = 0;

    // behavioural model: delayed view of the loop, run of disagreeing samples, request phase
    bit m_d1, m_d2, m_deb;
    bit run[$];
    int m_phase;
    int m_cnt8, m_cnt3;
    bit m_ov8, m_ov3;

    always #5 clk = ~clk;

    tlc_farm_sensor_cond #(.DEB_CYCLES(DEB), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .loop_raw(loop_raw), .light_farm(light_farm),
        .clr_cnt(clr_cnt), .sensor(sensor), .vehicle_cnt(vehicle_cnt), .overflow(overflow)
    );

    tlc_farm_sensor_cond #(.DEB_CYCLES(DEB), .CNT_W(3)) u3 (
        .clk(clk), .rst_n(rst_n), .loop_raw(loop_raw), .light_farm(light_farm),
        .clr_cnt(clr_cnt), .sensor(sensor3), .vehicle_cnt(cnt3), .overflow(ov3)
    );

    function automatic bit exp_sensor();
        return m_phase == 1 || (m_phase == 2 && m_deb);
    endfunction

    task automatic tick();
        bit seen, prev_deb, arr, g;
        @(posedge clk);
        if (!rst_n) begin
            m_d1 = 0; m_d2 = 0; m_deb = 0; run.delete();
            m_phase = 0; m_cnt8 = 0; m_cnt3 = 0; m_ov8 = 0; m_ov3 = 0;
        end else begin
            seen = m_d2;
            prev_deb = m_deb;
            g = light_farm == 3'b001;
            arr = 0;
            if (seen == m_deb) run.delete();
            else run.push_back(seen);
            if (run.size() >= DEB) begin
                m_deb = seen;
                run.delete();
                arr = seen;
            end
            if (clr_cnt) begin
                m_cnt8 = arr; m_cnt3 = arr; m_ov8 = 0; m_ov3 = 0;
            end else if (arr) begin
                if (m_cnt8 == 255) m_ov8 = 1; else m_cnt8++;
                if (m_cnt3 == 7) m_ov3 = 1; else m_cnt3++;
            end
            if (m_phase == 0) m_phase = arr ? 1 : 0;
            else if (m_phase == 1) m_phase = g ? 2 : 1;
            else if (!g) m_phase = prev_deb ? 1 : 0;
            m_d2 = m_d1;
            m_d1 = loop_raw;
        end
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 0; loop_raw = 0; light_farm = 3'b100; clr_cnt = 0;
        repeat (2) tick();
        rst_n = 1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 0; loop_raw = 1; light_farm = 3'b001; clr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (sensor !== 1'b0 || vehicle_cnt !== 8'd0 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc %0d: sensor=%0b cnt=%0d ov=%0b expected 0/0/0", i, sensor, vehicle_cnt, overflow);
            end
        end
        rst_n = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (sensor !== (i == 6)) begin
                failures++;
                $display("FAIL reset_latency edge %0d: sensor=%0b expected %0b", i, sensor, i == 6);
            end
        end
        checks++;
        if (vehicle_cnt !== 8'd1) begin
            failures++;
            $display("FAIL reset_first_count: cnt=%0d expected 1", vehicle_cnt);
        end
        tick();
        checks++;
        if (sensor !== 1'b1 || sensor !== exp_sensor()) begin
            failures++;
            $display("FAIL green_same_edge_serve: sensor=%0b expected 1 (model %0b)", sensor, exp_sensor());
        end
    endtask

    task automatic test_glitch();
        reset_dut();
        loop_raw = 1;
        repeat (3) tick();
        loop_raw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (sensor !== 1'b0 || vehicle_cnt !== 8'd0) begin
                failures++;
                $display("FAIL glitch_reject cyc %0d: sensor=%0b cnt=%0d expected 0/0", i, sensor, vehicle_cnt);
            end
        end
        loop_raw = 1;
        repeat (4) tick();
        loop_raw = 0;
        repeat (10) tick();
        checks++;
        if (sensor !== 1'b1 || vehicle_cnt !== 8'd1) begin
            failures++;
            $display("FAIL glitch_accept: sensor=%0b cnt=%0d expected 1/1", sensor, vehicle_cnt);
        end
    endtask

    task automatic test_latched();
        light_farm = 3'b100;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (sensor !== 1'b1) begin
                failures++;
                $display("FAIL latched_hold cyc %0d: sensor=%0b expected 1", i, sensor);
            end
        end
        light_farm = 3'b001;
        tick();
        checks++;
        if (sensor !== 1'b0 || m_phase != 2) begin
            failures++;
            $display("FAIL latched_serve: sensor=%0b expected 0 (model phase %0d)", sensor, m_phase);
        end
        light_farm = 3'b100;
        repeat (3) tick();
        light_farm = 3'b001;
        repeat (3) tick();
        checks++;
        if (sensor !== 1'b0 || m_phase != 0) begin
            failures++;
            $display("FAIL latched_idle: sensor=%0b expected 0 (model phase %0d)", sensor, m_phase);
        end
    endtask

    task automatic test_rerequest();
        reset_dut();
        loop_raw = 1;
        repeat (8) tick();
        light_farm = 3'b001;
        tick();
        light_farm = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (sensor !== 1'b1) begin
                failures++;
                $display("FAIL rerequest cyc %0d: sensor=%0b expected 1", i, sensor);
            end
        end
        checks++;
        if (m_phase != 1 || sensor !== exp_sensor()) begin
            failures++;
            $display("FAIL rerequest_wait: sensor=%0b model=%0b phase=%0d expected phase 1", sensor, exp_sensor(), m_phase);
        end
    endtask

    task automatic arrive();
        loop_raw = 1;
        repeat (6) tick();
        loop_raw = 0;
        repeat (6) tick();
    endtask

    task automatic test_saturation();
        reset_dut();
        repeat (9) arrive();
        checks++;
        if (cnt3 !== 3'd7 || ov3 !== 1'b1) begin
            failures++;
            $display("FAIL sat3: cnt=%0d ov=%0b expected 7/1", cnt3, ov3);
        end
        checks++;
        if (vehicle_cnt !== 8'd9 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL sat8: cnt=%0d ov=%0b expected 9/0", vehicle_cnt, overflow);
        end
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        checks++;
        if (cnt3 !== 3'd0 || ov3 !== 1'b0 || vehicle_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clear: cnt3=%0d ov3=%0b cnt8=%0d expected 0/0/0", cnt3, ov3, vehicle_cnt);
        end
        repeat (2) arrive();
        loop_raw = 1;
        repeat (5) tick();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        checks++;
        if (cnt3 !== 3'd1 || ov3 !== 1'b0 || vehicle_cnt !== 8'd1) begin
            failures++;
            $display("FAIL clear_with_arrival: cnt3=%0d ov3=%0b cnt8=%0d expected 1/0/1", cnt3, ov3, vehicle_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        reset_dut();
        loop_raw = 1;
        repeat (8) tick();
        checks++;
        if (sensor !== 1'b1) begin
            failures++;
            $display("FAIL mid_wait_pre: sensor=%0b expected 1", sensor);
        end
        rst_n = 0;
        tick();
        checks++;
        if (sensor !== 1'b0 || vehicle_cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_wait_reset: sensor=%0b cnt=%0d expected 0/0", sensor, vehicle_cnt);
        end
        rst_n = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (sensor !== (i == 6) || vehicle_cnt !== 8'(i == 6)) begin
                failures++;
                $display("FAIL mid_wait_rearm edge %0d: sensor=%0b cnt=%0d expected %0b/%0d", i, sensor, vehicle_cnt, i == 6, i == 6);
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) loop_raw = ~loop_raw;
            if ($urandom_range(0, 15) == 0) light_farm = 3'($urandom_range(0, 7));
            clr_cnt = $urandom_range(0, 60) == 0;
            rst_n = $urandom_range(0, 400) != 0;
            tick();
            checks++;
            if (sensor !== exp_sensor() || sensor3 !== exp_sensor()) begin
                failures++;
                $display("FAIL rnd_sensor cyc %0d: sensor=%0b sensor3=%0b expected %0b", i, sensor, sensor3, exp_sensor());
            end
            checks++;
            if (vehicle_cnt !== 8'(m_cnt8) || overflow !== m_ov8) begin
                failures++;
                $display("FAIL rnd_cnt8 cyc %0d: cnt=%0d ov=%0b expected %0d/%0b", i, vehicle_cnt, overflow, m_cnt8, m_ov8);
            end
            checks++;
            if (cnt3 !== 3'(m_cnt3) || ov3 !== m_ov3) begin
                failures++;
                $display("FAIL rnd_cnt3 cyc %0d: cnt=%0d ov=%0b expected %0d/%0b", i, cnt3, ov3, m_cnt3, m_ov3);
            end
        end
        rst_n = 1;
        clr_cnt = 0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_latched();
        test_rerequest();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
